// File: rtl/ifetch.sv
// ifetch: instruction fetch stage of the rv32 pipeline.
//   Holds the PC and drives the imem word address. It captures the
//   combinational imem read data and offers {instr, pc} to decode
//   over a valid/ready handshake. It also supports stall, redirect/flush
//   from execute, and a sticky fault on a misaligned or out-of-range PC.
//
// Ports
//   i_clk, i_rst         clock; asynchronous active-high reset
//   i_enable             fetch permitted (0 = no new fetches)
//   o_imem_addr          imem word index = {2'b00, r_pc[31:2]}
//   i_imem_data          instruction returned combinationally by imem
//   o_valid/i_ready      decode handshake
//   o_instr, o_pc        captured instruction and its byte address
//   i_redirect(_pc)      taken branch/jump: flush and refetch at target
//   o_fault, o_fault_pc  sticky fault flag and the offending PC
//   o_fetch_count        number of completed decode handshakes (wraps)
//   o_state              current FSM state, for observation
//
// Handshake: a transfer happens on a rising edge where o_valid & i_ready.
// While o_valid & !i_ready, o_instr/o_pc/o_valid hold unchanged until the
// transfer or a redirect. A redirect drops whatever is held.
module ifetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_fault,
  output logic [31:0] o_fault_pc,
  output logic [31:0] o_fetch_count,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

  state_t      state, state_next;
  logic [31:0] r_pc;

  // Control decisions from the FSM process, consumed by the datapath.
  logic        do_load;
  logic        do_redir;
  logic        do_fault;
  logic        do_flush;
  logic        xfer;
  logic [31:0] fault_addr;

  function automatic logic pc_bad(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || ({2'b00, pc[31:2]} >= DEPTH_W);
  endfunction

  assign o_imem_addr = {2'b00, r_pc[31:2]};
  assign o_state     = state;
  assign xfer        = o_valid & i_ready;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next state and control
  always_comb begin
    state_next = state;
    do_load    = 1'b0;
    do_redir   = 1'b0;
    do_fault   = 1'b0;
    do_flush   = 1'b0;
    fault_addr = r_pc;
    case (state)
      S_IDLE, S_RUN: begin
        if (i_redirect) begin
          // Redirect outranks everything except reset; the target is
          // checked here so a bad target faults without ever loading.
          if (pc_bad(i_redirect_pc)) begin
            do_fault   = 1'b1;
            fault_addr = i_redirect_pc;
            state_next = S_FAULT;
          end else begin
            do_redir   = 1'b1;
            state_next = i_enable ? S_RUN : S_IDLE;
          end
        end else if (state == S_IDLE) begin
          if (i_enable) state_next = S_RUN;
        end else if (!o_valid || i_ready) begin
          // Output slot is free (or frees this cycle).
          if (!i_enable) begin
            do_flush   = 1'b1;
            state_next = S_IDLE;
          end else if (pc_bad(r_pc)) begin
            do_fault   = 1'b1;
            fault_addr = r_pc;
            state_next = S_FAULT;
          end else begin
            do_load = 1'b1;
          end
        end
      end
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc          <= RESET_PC;
      o_valid       <= 1'b0;
      o_instr       <= 32'h0;
      o_pc          <= 32'h0;
      o_fault       <= 1'b0;
      o_fault_pc    <= 32'h0;
      o_fetch_count <= 32'h0;
    end else begin
      if (do_fault) begin
        o_fault    <= 1'b1;
        o_fault_pc <= fault_addr;
        o_valid    <= 1'b0;
      end else if (do_redir) begin
        r_pc    <= i_redirect_pc;
        o_valid <= 1'b0;
      end else if (do_load) begin
        o_instr <= i_imem_data;
        o_pc    <= r_pc;
        o_valid <= 1'b1;
        r_pc    <= r_pc + 32'd4;
      end else if (do_flush) begin
        o_valid <= 1'b0;
      end
      // A transfer coinciding with a redirect or fault still counts.
      if (xfer) o_fetch_count <= o_fetch_count + 32'd1;
    end
  end

endmodule
